// File: rtl/key_scheduler.sv
// Piano key event scheduler: key edge detection, per-key pending bits, round-robin event output
// and a last-press-priority active note. Define KEY_SCHED_RELEASE_EN to also emit release events.
module key_scheduler #(
    parameter int NUM_KEYS = 8,
    parameter int KEY_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                event_ready,
    output logic                event_valid,
    output logic [KEY_W-1:0]    event_key,
    output logic                event_press,
    output logic                active_valid,
    output logic [KEY_W-1:0]    active_key,
    output logic                overflow
);
    localparam logic [NUM_KEYS-1:0] KeyLsb = {{(NUM_KEYS - 1){1'b0}}, 1'b1};

    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] pend_press;
    logic [NUM_KEYS-1:0] press_edge;
    logic [NUM_KEYS-1:0] rel_edge;
    logic [NUM_KEYS-1:0] pend_any;
    logic [NUM_KEYS-1:0] drop;
    logic [NUM_KEYS-1:0] grant_mask;
    logic [NUM_KEYS-1:0] clr_press;
    logic [NUM_KEYS-1:0] fb_base;
    logic [NUM_KEYS-1:0] fb_mask;
    logic [KEY_W-1:0]    rr_ptr;
    logic [KEY_W-1:0]    rr_next;
    logic [KEY_W-1:0]    grant_idx;
    logic [KEY_W-1:0]    fb_idx;
    logic                grant_found;
    logic                grant_press;
    logic                fb_found;
    logic                load;
    logic                handshake;
    logic                rel_active;

    assign press_edge = key_in & ~key_prev;
    assign rel_edge   = ~key_in & key_prev;
    assign load       = ~event_valid | event_ready;
    assign handshake  = event_valid & event_ready;
    assign grant_mask = KeyLsb << grant_idx;
    assign clr_press  = (load && grant_found && grant_press) ? grant_mask : '0;
    assign fb_mask    = fb_base & ~(KeyLsb << active_key);
    assign rr_next    = (int'(grant_idx) == NUM_KEYS - 1) ? '0 : grant_idx + 1'b1;

`ifdef KEY_SCHED_RELEASE_EN
    logic [NUM_KEYS-1:0] pend_release;
    logic [NUM_KEYS-1:0] clr_release;

    assign pend_any    = pend_press | pend_release;
    assign grant_press = pend_press[grant_idx];
    assign clr_release = (load && grant_found && !grant_press) ? grant_mask : '0;
    // A third edge on a key with both event types already queued has nowhere to go.
    assign drop        = pend_press & pend_release & (press_edge | rel_edge);
    assign fb_base     = key_prev;
    assign rel_active  = handshake & ~event_press & active_valid & (event_key == active_key);
`else
    assign pend_any    = pend_press;
    assign grant_press = 1'b1;
    assign drop        = pend_press & press_edge;
    // Without release events the active note follows the key level directly.
    assign fb_base     = key_in;
    assign rel_active  = active_valid & rel_edge[active_key];
`endif

    // Round-robin search starting at rr_ptr, wrapping past NUM_KEYS-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < NUM_KEYS; off++) begin
            if (!grant_found && pend_any[(int'(rr_ptr) + off) % NUM_KEYS]) begin
                grant_found = 1'b1;
                grant_idx   = KEY_W'((int'(rr_ptr) + off) % NUM_KEYS);
            end
        end
    end

    always_comb begin
        fb_found = 1'b0;
        fb_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (fb_mask[i]) begin
                fb_found = 1'b1;
                fb_idx   = KEY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev     <= '0;
            pend_press   <= '0;
`ifdef KEY_SCHED_RELEASE_EN
            pend_release <= '0;
`endif
            rr_ptr       <= '0;
            event_valid  <= 1'b0;
            event_key    <= '0;
            event_press  <= 1'b0;
            active_valid <= 1'b0;
            active_key   <= '0;
            overflow     <= 1'b0;
        end else begin
            key_prev     <= key_in;
            overflow     <= overflow | (|drop);
            pend_press   <= (pend_press & ~clr_press) | (press_edge & ~drop);
`ifdef KEY_SCHED_RELEASE_EN
            pend_release <= (pend_release & ~clr_release) | (rel_edge & ~drop);
`endif
            if (load) begin
                event_valid <= grant_found;
                if (grant_found) begin
                    event_key   <= grant_idx;
                    event_press <= grant_press;
                    rr_ptr      <= rr_next;
                end
            end
            if (handshake && event_press) begin
                active_valid <= 1'b1;
                active_key   <= event_key;
            end else if (rel_active) begin
                active_valid <= fb_found;
                if (fb_found) begin
                    active_key <= fb_idx;
                end
            end
        end
    end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameter: NUM_KEYS, default 8, number of piano key inputs; allowed values are 2 to 16.
REQ-002 Parameter: KEY_W, default 3, width of a key index; SHALL equal ceil(log2(NUM_KEYS)).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_in  input  NUM_KEYS  debounced key levels, 1 = key held.
REQ-006 event_ready  input  1  downstream tone generator accepts the current event.
REQ-007 event_valid  output  1  an event is presented.
REQ-008 event_key  output  KEY_W  key index of the presented event.
REQ-009 event_press  output  1  1 = press event, 0 = release event.
REQ-010 active_valid  output  1  a note is currently sounding.
REQ-011 active_key  output  KEY_W  index of the sounding key (last-press priority).
REQ-012 overflow  output  1  sticky flag: a key edge was dropped.

Function
REQ-013 key_in SHALL be registered into key_prev every cycle; press edge = key_in & ~key_prev; release edge = ~key_in & key_prev.
REQ-014 A press edge on key i SHALL set pend_press[i]; a release edge on key i SHALL set pend_release[i] on the same edge.
REQ-015 If pend_press[i] and pend_release[i] are both already set and a further edge arrives on key i, the edge SHALL be dropped and overflow SHALL be set.
REQ-016 Output register state: load enabled when event_valid=0 or (event_valid=1 and event_ready=1).
REQ-017 On load, a round-robin arbiter SHALL grant the first key j with pending bits, searching from rr_ptr upward with wrap-around at NUM_KEYS-1 to 0.
REQ-018 Within a granted key, press SHALL win over release; only the emitted bit is cleared, in the same cycle the output register is loaded.
REQ-019 rr_ptr SHALL advance to (j+1) mod NUM_KEYS after a grant; rr_ptr SHALL stay unchanged when no bits are pending.
REQ-020 If nothing is pending on a load cycle, event_valid SHALL deassert at that edge.
REQ-021 While event_valid=1 and event_ready=0, event_key and event_press SHALL hold stable.
REQ-022 Latency: a key_in change sampled at edge E0 SHALL yield event_valid=1 at E1 when the output register is empty and no other requests are pending.
REQ-023 Pending-bit set and clear on the same key in the same cycle: the clear applies to the emitted bit only; a newly arriving edge of the other type is retained.
REQ-024 On handshake of a press event for key k: active_key=k and active_valid=1 at the next edge.
REQ-025 On handshake of a release event for key k == active_key: fall back to the lowest-index key with key_prev=1 (excluding k); if none, active_valid=0.
REQ-026 A release event for a non-active key SHALL NOT change active_key or active_valid.
REQ-027 overflow SHALL remain 1 until reset.

Reset
REQ-028 Reset SHALL force the following values asynchronously: event_valid=0, event_key=0, event_press=0, active_valid=0, active_key=0, overflow=0, key_prev=0, all pending bits=0, rr_ptr=0.
REQ-029 Keys already held at reset release SHALL produce press events starting one cycle after the release of reset.
REQ-030 Asserting reset mid-handshake SHALL discard the presented event and all pending bits.

Configuration
REQ-031 Macro KEY_SCHED_RELEASE_EN defined: release events are generated exactly as specified above.
REQ-032 KEY_SCHED_RELEASE_EN undefined:
- no pend_release storage is built;
- release edges are ignored for events;
- event_press SHALL be tied to 1;
- REQ-015 SHALL apply to a second press while pend_press is set;
- active_valid SHALL clear when key_prev for active_key falls to 0 and no other key is held, otherwise fall back per REQ-025.

Verification
REQ-033 Case 1: reset, event_ready=1, key_in 0x00 to 0x04 -> two cycles later event_valid=1, event_key=2, event_press=1; next cycle active_key=2, active_valid=1.
REQ-034 Case 2: key_in 0x00 to 0x81 in one cycle, rr_ptr=0, ready=1 -> events key 0 then key 7 on consecutive cycles; then key_in=0x00 -> releases key 0 then key 7 (RELEASE_EN).
REQ-035 Case 3: ready=0 with keys 1, 3, 5 pressed -> event_key=1 held stable for 10 cycles; after ready=1, the event order is 1, 3, 5.
REQ-036 Case 4: ready=0 on key 4, with key_in bit 4 toggled 1, 0, 1 -> overflow=1; only one press and one release for key 4 are emitted.
REQ-037 Case 5: hold keys 2 and 6, press 6 last, release 6 -> active_key=2, active_valid stays 1; release 2 -> active_valid=0.
REQ-038 Case 6: assert reset while event_valid=1 and ready=0 -> all outputs 0 immediately, with no clock edge needed.
